// File: rtl/fs_pkg.sv
// Shared definitions for the registered full subtractor.
// The borrow equation lives here so the cell and any reference model use one definition.
package fs_pkg;

    // Reset value of the registered difference
    localparam int unsigned FS_RST_DIFF = 0;

    // 1-bit borrow out of a - b - c
    function automatic logic fs_borrow(input logic a, input logic b, input logic c);
        return (~a & b) | (~(a ^ b) & c);
    endfunction

endpackage

// File: rtl/fs_cell.sv
// Combinational 1-bit full subtractor cell: diff = a - b - bin, bout = borrow out.
module fs_cell
    import fs_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = fs_borrow(a, b, bin);

endmodule

// File: rtl/full_subtractor_reg.sv
// Registered WIDTH-bit ripple-borrow subtractor: {bout, diff} = a - b - bin,
// one cycle of latency, with a valid flag that follows in_valid.
// Define FS_OVF_EN to add a registered signed-overflow output, ovf.
// diff/bout (and ovf) only load on accepted inputs, so X on a/b/bin while
// in_valid is low never reaches the outputs.
module full_subtractor_reg
    import fs_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef FS_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH:0]   borrow;
    logic [WIDTH-1:0] diff_next;

    assign borrow[0] = bin;

    // Borrow ripples from the LSB cell up to the MSB cell
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fs_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .bin  (borrow[i]),
            .diff (diff_next[i]),
            .bout (borrow[i+1])
        );
    end

    // Valid flag: pulses for exactly one cycle per accepted input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

    // Result register: loads on accepted inputs, otherwise holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff <= WIDTH'(FS_RST_DIFF);
            bout <= 1'b0;
        end else if (in_valid) begin
            diff <= diff_next;
            bout <= borrow[WIDTH];
        end
    end

`ifdef FS_OVF_EN
    logic ovf_next;

    // Signed overflow: operand signs differ and the result sign differs from a
    assign ovf_next = (a[WIDTH-1] != b[WIDTH-1]) && (diff_next[WIDTH-1] != a[WIDTH-1]);

    // Overflow register travels with diff
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= ovf_next;
        end
    end
`endif

endmodule

// File: tb/tb_full_subtractor_reg.sv
// Self-checking bench for full_subtractor_reg: a WIDTH=1 and a WIDTH=8 instance
// share clock and reset; directed tables, reset/hold sequences, random stream.
module tb_full_subtractor_reg;

    typedef struct {
        logic a;
        logic b;
        logic bin;
        logic d;
        logic bo;
        logic ov;
    } vec1_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } vec8_t;

    logic clk = 1'b0;
    logic rst_n;

    logic       iv1, a1, b1, bin1, ov1, d1, bo1;
    logic       iv8, bin8, ov8, bo8;
    logic [7:0] a8, b8, d8;
`ifdef FS_OVF_EN
    logic       ovf1, ovf8;
`endif

    int checks   = 0;
    int failures = 0;

    vec1_t tv1 [8];
    vec8_t tv8 [7];

    always #5 clk = ~clk;

    full_subtractor_reg #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv1),
        .a         (a1),
        .b         (b1),
        .bin       (bin1),
        .out_valid (ov1),
        .diff      (d1),
        .bout      (bo1)
`ifdef FS_OVF_EN
        ,
        .ovf       (ovf1)
`endif
    );

    full_subtractor_reg #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv8),
        .a         (a8),
        .b         (b8),
        .bin       (bin8),
        .out_valid (ov8),
        .diff      (d8),
        .bout      (bo8)
`ifdef FS_OVF_EN
        ,
        .ovf       (ovf8)
`endif
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] ed, input logic ebo, input logic eov,
                        input logic eovf);
        chk({name, "_diff"}, 16'(d8), 16'(ed));
        chk({name, "_bout"}, 16'(bo8), 16'(ebo));
        chk({name, "_valid"}, 16'(ov8), 16'(eov));
`ifdef FS_OVF_EN
        chk({name, "_ovf"}, 16'(ovf8), 16'(eovf));
`else
        if (eovf === 1'bx) $display("unused");
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] r;
        logic       eovf;

        //            a     b     bin   d     bo    ov
        tv1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tv1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tv1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tv1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tv1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tv1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tv1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        tv8[0] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
        tv8[1] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        tv8[2] = '{8'h55, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0};
        tv8[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        tv8[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        tv8[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tv8[6] = '{8'h10, 8'h05, 1'b1, 8'h0A, 1'b0, 1'b0};

        rst_n = 1'b0;
        iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
        iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;

        // Reset state
        #12;
        chk("rst_w1_diff", 16'(d1), 16'h0);
        chk("rst_w1_bout", 16'(bo1), 16'h0);
        chk("rst_w1_valid", 16'(ov1), 16'h0);
        chk8("rst_w8", 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // WIDTH=1 truth table, back-to-back
        for (int i = 0; i < 8; i++) begin
            iv1 = 1'b1; a1 = tv1[i].a; b1 = tv1[i].b; bin1 = tv1[i].bin;
            @(posedge clk);
            #1;
            chk($sformatf("tt%0d_diff", i), 16'(d1), 16'(tv1[i].d));
            chk($sformatf("tt%0d_bout", i), 16'(bo1), 16'(tv1[i].bo));
            chk($sformatf("tt%0d_valid", i), 16'(ov1), 16'h1);
`ifdef FS_OVF_EN
            chk($sformatf("tt%0d_ovf", i), 16'(ovf1), 16'(tv1[i].ov));
`endif
        end
        iv1 = 1'b0;

        // WIDTH=8 directed vectors and boundaries
        for (int i = 0; i < 7; i++) begin
            iv8 = 1'b1; a8 = tv8[i].a; b8 = tv8[i].b; bin8 = tv8[i].bin;
            @(posedge clk);
            #1;
            chk8($sformatf("v8_%0d", i), tv8[i].d, tv8[i].bo, 1'b1, tv8[i].ov);
        end

        // Hold: in_valid low, random operands, last result (0x0A) must stay
        for (int i = 0; i < 3; i++) begin
            iv8 = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            @(posedge clk);
            #1;
            chk8($sformatf("hold%0d", i), 8'h0A, 1'b0, 1'b0, 1'b0);
        end

        // Reset mid-stream discards the result in flight
        iv8 = 1'b1; a8 = 8'h20; b8 = 8'h10; bin8 = 1'b0;
        @(posedge clk);
        #1;
        chk8("pre_rst", 8'h10, 1'b0, 1'b1, 1'b0);
        a8 = 8'h03; b8 = 8'h05; bin8 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk8("rst_async", 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk8("rst_held", 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk8("post_rst", 8'hFE, 1'b1, 1'b1, 1'b0);

        // Random back-to-back stream
        for (int i = 0; i < 1000; i++) begin
            iv8 = 1'b1;
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            r = {1'b0, a8} - {1'b0, b8} - {8'h00, bin8};
            eovf = (a8[7] != b8[7]) && (r[7] != a8[7]);
            @(posedge clk);
            #1;
            chk8("rand", r[7:0], r[8], 1'b1, eovf);
        end
        iv8 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
